mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 49 ++++
 rtl/mc_controller_if.sv | 34 +++
 rtl/mc_controller_aludec.sv | 31 +++
 rtl/mc_controller.sv | 121 ++++++++++++
 tb/tb_mc_controller.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
//   state_t      : main FSM states
//   aluop_t      : ALU operation class handed from the FSM to aludec
//   OP_* / F_*   : opcode and R-type funct field values
//   SRCB_*, PC_*, ALU_* : datapath mux selects and ALU operation codes
package mc_controller_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, ALUWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;

  // ALUOP_ADD is the all-zero encoding so states that do not name an ALU
  // operation fall back to add.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath signal bundle.
//   op, funct, zero          : instruction fields and ALU flag from the datapath
//   iord .. alucontrol       : datapath control strobes and mux selects
//   illegal_op               : unsupported-opcode pulse
// master = controller side, slave = datapath side.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal_op;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op
  );
endinterface

// File: rtl/mc_controller_aludec.sv
// ALU operation decoder.
//   aluop      in  operation class from the main FSM
//   funct      in  R-type function field
//   alucontrol out 3-bit ALU operation code
module aludec
  import mc_controller_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: main FSM plus Moore output decode.
//   clk   in  rising-edge clock
//   reset in  synchronous active-high reset; returns FSM to FETCH and
//             holds every write/load enable and illegal_op low
//   bus   master side of mc_controller_if (op/funct/zero in, controls out)
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  state_t state, state_nx;
  aluop_t aluop;
  logic   pcwrite, branch, illegal;
  logic   memwrite_s, irwrite_s, regwrite_s;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = FETCH;
    aluop       = ALUOP_ADD;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    illegal     = 1'b0;
    memwrite_s  = 1'b0;
    irwrite_s   = 1'b0;
    regwrite_s  = 1'b0;
    bus.iord    = 1'b0;
    bus.regdst  = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca = 1'b0;
    bus.alusrcb = SRCB_REG;
    bus.pcsrc   = PC_ALURES;
    case (state)
      FETCH: begin
        irwrite_s   = 1'b1;
        bus.alusrcb = SRCB_FOUR;
        pcwrite     = 1'b1;
        state_nx    = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        bus.alusrcb = SRCB_IMMSH;
        case (bus.op)
          OP_LW, OP_SW: state_nx = MEMADR;
          OP_RTYPE:     state_nx = RTYPEEX;
          OP_BEQ:       state_nx = BEQEX;
          OP_ADDI:      state_nx = ADDIEX;
          OP_J:         state_nx = JEX;
          default: begin
            illegal  = 1'b1;
            state_nx = FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        state_nx    = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.iord = 1'b1;
        state_nx = MEMWB;
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite_s   = 1'b1;
      end
      MEMWR: begin
        bus.iord   = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
        state_nx    = ALUWB;
      end
      ALUWB: begin
        bus.regdst = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        bus.pcsrc   = PC_ALUOUT;
        branch      = 1'b1;
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        state_nx    = ADDIWB;
      end
      ADDIWB: regwrite_s = 1'b1;
      JEX: begin
        bus.pcsrc = PC_JUMP;
        pcwrite   = 1'b1;
      end
      default: state_nx = FETCH;
    endcase
  end

  // Enables are masked by reset directly so nothing is written during the
  // reset cycle, even from the state that was live when reset arrived.
  assign bus.memwrite   = ~reset & memwrite_s;
  assign bus.irwrite    = ~reset & irwrite_s;
  assign bus.regwrite   = ~reset & regwrite_s;
  assign bus.pcen       = ~reset & (pcwrite | (branch & bus.zero));
  assign bus.illegal_op = ~reset & illegal;

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: cycle-by-cycle vector table plus reset and
// illegal-opcode sequences.
module tb_mc_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   ill_cnt = 0;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  // Packing: iord mw ir rd mtr rw alusrca alusrcb[2] pcsrc[2] pcen alu[3] ill
  function automatic logic [15:0] mk(input logic iord, mw, ir, rd, mtr, rw, a,
                                     input logic [1:0] b, pc,
                                     input logic pcen,
                                     input logic [2:0] alu,
                                     input logic ill);
    return {iord, mw, ir, rd, mtr, rw, a, b, pc, pcen, alu, ill};
  endfunction

  function automatic logic [15:0] outv();
    return {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
            bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen,
            bus.alucontrol, bus.illegal_op};
  endfunction

  logic [15:0] e_fetch, e_fetch_rst, e_decode, e_decode_ill, e_memadr, e_memrd;
  logic [15:0] e_memwb, e_memwr, e_aluwb, e_addiwb, e_jex;

  function automatic logic [15:0] e_rtype(input logic [2:0] alu);
    return mk(0,0,0,0,0,0,1,2'b00,2'b00,0,alu,0);
  endfunction

  function automatic logic [15:0] e_beq(input logic pcen);
    return mk(0,0,0,0,0,0,1,2'b00,2'b01,pcen,3'b110,0);
  endfunction

  task automatic push(input logic r, input logic [5:0] o, f, input logic z,
                      input logic [15:0] e, input string nm);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic [5:0] o, f, input logic z,
                      input logic [15:0] e, input string nm);
    logic [15:0] got;
    reset = r; bus.op = o; bus.funct = f; bus.zero = z;
    @(negedge clk);
    got = outv();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", nm, got, e);
    end
    if (got[0] === 1'b1) ill_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    e_fetch      = mk(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0);
    e_fetch_rst  = mk(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,0);
    e_decode     = mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0);
    e_decode_ill = mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,1);
    e_memadr     = mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0);
    e_memrd      = mk(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0);
    e_memwb      = mk(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b010,0);
    e_memwr      = mk(1,1,0,0,0,0,0,2'b00,2'b00,0,3'b010,0);
    e_aluwb      = mk(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b010,0);
    e_addiwb     = mk(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010,0);
    e_jex        = mk(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0);

    // reset for two cycles
    push(1, 6'b100011, 6'b0, 0, e_fetch_rst, "reset0");
    push(1, 6'b100011, 6'b0, 0, e_fetch_rst, "reset1");
    // lw: 5 cycles
    push(0, 6'b100011, 6'b0, 0, e_fetch,  "lw_fetch");
    push(0, 6'b100011, 6'b0, 0, e_decode, "lw_decode");
    push(0, 6'b100011, 6'b0, 0, e_memadr, "lw_memadr");
    push(0, 6'b100011, 6'b0, 0, e_memrd,  "lw_memrd");
    push(0, 6'b100011, 6'b0, 0, e_memwb,  "lw_memwb");
    // sw: 4 cycles
    push(0, 6'b101011, 6'b0, 0, e_fetch,  "sw_fetch");
    push(0, 6'b101011, 6'b0, 0, e_decode, "sw_decode");
    push(0, 6'b101011, 6'b0, 0, e_memadr, "sw_memadr");
    push(0, 6'b101011, 6'b0, 0, e_memwr,  "sw_memwr");
    // R-type slt
    push(0, 6'b000000, 6'b101010, 0, e_fetch,           "slt_fetch");
    push(0, 6'b000000, 6'b101010, 0, e_decode,          "slt_decode");
    push(0, 6'b000000, 6'b101010, 0, e_rtype(3'b111),   "slt_ex");
    push(0, 6'b000000, 6'b101010, 0, e_aluwb,           "slt_wb");
    // other funct codes, checked in RTYPEEX
    push(0, 6'b000000, 6'b100010, 0, e_fetch,           "sub_fetch");
    push(0, 6'b000000, 6'b100010, 0, e_decode,          "sub_decode");
    push(0, 6'b000000, 6'b100010, 0, e_rtype(3'b110),   "sub_ex");
    push(0, 6'b000000, 6'b100010, 0, e_aluwb,           "sub_wb");
    push(0, 6'b000000, 6'b100100, 0, e_fetch,           "and_fetch");
    push(0, 6'b000000, 6'b100100, 0, e_decode,          "and_decode");
    push(0, 6'b000000, 6'b100100, 0, e_rtype(3'b000),   "and_ex");
    push(0, 6'b000000, 6'b100100, 0, e_aluwb,           "and_wb");
    push(0, 6'b000000, 6'b100101, 0, e_fetch,           "or_fetch");
    push(0, 6'b000000, 6'b100101, 0, e_decode,          "or_decode");
    push(0, 6'b000000, 6'b100101, 0, e_rtype(3'b001),   "or_ex");
    push(0, 6'b000000, 6'b100101, 0, e_aluwb,           "or_wb");
    push(0, 6'b000000, 6'b100000, 0, e_fetch,           "add_fetch");
    push(0, 6'b000000, 6'b100000, 0, e_decode,          "add_decode");
    push(0, 6'b000000, 6'b100000, 0, e_rtype(3'b010),   "add_ex");
    push(0, 6'b000000, 6'b100000, 0, e_aluwb,           "add_wb");
    push(0, 6'b000000, 6'b111111, 0, e_fetch,           "unk_fetch");
    push(0, 6'b000000, 6'b111111, 0, e_decode,          "unk_decode");
    push(0, 6'b000000, 6'b111111, 0, e_rtype(3'b010),   "unk_ex");
    push(0, 6'b000000, 6'b111111, 0, e_aluwb,           "unk_wb");
    // beq taken: zero held high outside BEQEX must not raise pcen there
    push(0, 6'b000100, 6'b0, 1, e_fetch,   "beq1_fetch");
    push(0, 6'b000100, 6'b0, 1, e_decode,  "beq1_decode");
    push(0, 6'b000100, 6'b0, 1, e_beq(1),  "beq1_ex");
    // beq not taken
    push(0, 6'b000100, 6'b0, 0, e_fetch,   "beq0_fetch");
    push(0, 6'b000100, 6'b0, 0, e_decode,  "beq0_decode");
    push(0, 6'b000100, 6'b0, 0, e_beq(0),  "beq0_ex");
    // addi
    push(0, 6'b001000, 6'b0, 0, e_fetch,   "addi_fetch");
    push(0, 6'b001000, 6'b0, 0, e_decode,  "addi_decode");
    push(0, 6'b001000, 6'b0, 0, e_memadr,  "addi_ex");
    push(0, 6'b001000, 6'b0, 0, e_addiwb,  "addi_wb");
    // j
    push(0, 6'b000010, 6'b0, 0, e_fetch,   "j_fetch");
    push(0, 6'b000010, 6'b0, 0, e_decode,  "j_decode");
    push(0, 6'b000010, 6'b0, 0, e_jex,     "j_ex");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].exp, tbl[i].name);

    // illegal opcode: one-cycle pulse in DECODE, then straight back to FETCH
    ill_cnt = 0;
    step(0, 6'b111111, 6'b0, 0, e_fetch,      "ill_fetch");
    step(0, 6'b111111, 6'b0, 0, e_decode_ill, "ill_decode");
    step(0, 6'b100011, 6'b0, 0, e_fetch,      "ill_next_fetch");
    checks++;
    if (ill_cnt != 1) begin
      errors++;
      $display("FAIL ill_pulse_count got=%0d exp=1", ill_cnt);
    end

    // reset during lw MEMRD aborts the load
    step(0, 6'b100011, 6'b0, 0, e_decode,    "rst_lw_decode");
    step(0, 6'b100011, 6'b0, 0, e_memadr,    "rst_lw_memadr");
    step(1, 6'b100011, 6'b0, 1, e_memrd,     "rst_in_memrd");
    step(1, 6'b100011, 6'b0, 1, e_fetch_rst, "rst_held_fetch");
    step(0, 6'b100011, 6'b0, 0, e_fetch,     "rst_release_fetch");
    step(0, 6'b100011, 6'b0, 0, e_decode,    "rst_release_decode");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
